reg_file_param: RTL

REG_FILE_PARAM -- requirements
Module: reg_file_param

---
 rtl/reg_file_param_pkg.sv | 14 +
 rtl/reg_file_clear_fsm.sv | 70 +++++++
 rtl/reg_file_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/reg_file_param_pkg.sv
// Purpose: shared definitions for the parameterised register file:
//          default geometry constants and sweep-clear FSM state encodings.
// Ports:   none (package).
package reg_file_param_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Purpose: sweep-clear sequencer. On i_clear in IDLE it walks a pointer over
//          every register address, one per cycle, then returns to IDLE.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_clear          request a sweep (ignored while sweeping)
//   o_busy           sweep in progress (state decode)
//   o_clr_en         zero the register at o_clr_addr this cycle
//   o_clr_addr       sweep pointer
module reg_file_clear_fsm
    import reg_file_param_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    output logic                  o_busy,
    output logic                  o_clr_en,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    clr_state_e            r_state;
    clr_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;

    // State and pointer registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state: terminate on the all-ones pointer so no overflow state exists
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (i_clear) begin
                    w_state_nxt = ST_SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + ADDR_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == ST_SWEEP);
    assign o_clr_en   = (r_state == ST_SWEEP);
    assign o_clr_addr = r_ptr;

endmodule

// File: rtl/reg_file_param.sv
// Purpose: parameterised 2-read/1-write register file with registered read
//          data, write-first bypass, optional hardwired-zero register 0 and a
//          sweep-clear of the whole array.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_read, i_write       read / write requests (ignored while o_busy)
//   i_clear               start sweep-clear
//   i_addr_r1, i_addr_r2  read addresses
//   i_addr_w, i_data_w    write address / data
//   o_data_r1, o_data_r2  registered read data (held when no read)
//   o_r_valid             one-cycle pulse when read data updated
//   o_busy                sweep-clear in progress
module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          ZERO_REG   = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic                  i_clear,
    input  logic [ADDR_WIDTH-1:0] i_addr_r1,
    input  logic [ADDR_WIDTH-1:0] i_addr_r2,
    input  logic [ADDR_WIDTH-1:0] i_addr_w,
    input  logic [DATA_WIDTH-1:0] i_data_w,
    output logic [DATA_WIDTH-1:0] o_data_r1,
    output logic [DATA_WIDTH-1:0] o_data_r2,
    output logic                  o_r_valid,
    output logic                  o_busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_r1;
    logic [DATA_WIDTH-1:0] r_data_r2;
    logic                  r_r_valid;

    logic                  w_busy;
    logic                  w_clr_en;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    reg_file_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_fsm (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (i_clear),
        .o_busy     (w_busy),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    // Writes to r0 are dropped when it is hardwired; this also kills the bypass
    assign w_wr_en = i_write && !w_busy && !(ZERO_REG && (i_addr_w == '0));
    assign w_rd_en = i_read && !w_busy;

    // Read mux with write-first bypass
    always_comb begin
        w_rd1 = r_mem[i_addr_r1];
        w_rd2 = r_mem[i_addr_r2];
        if (w_wr_en && (i_addr_r1 == i_addr_w)) w_rd1 = i_data_w;
        if (w_wr_en && (i_addr_r2 == i_addr_w)) w_rd2 = i_data_w;
        if (ZERO_REG && (i_addr_r1 == '0))      w_rd1 = '0;
        if (ZERO_REG && (i_addr_r2 == '0))      w_rd2 = '0;
    end

    // Register array: sweep-clear has the write port while busy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[i_addr_w] <= i_data_w;
        end
    end

    // Read data registers hold their value when no read is performed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data_r1 <= '0;
            r_data_r2 <= '0;
            r_r_valid <= 1'b0;
        end else begin
            r_r_valid <= w_rd_en;
            if (w_rd_en) begin
                r_data_r1 <= w_rd1;
                r_data_r2 <= w_rd2;
            end
        end
    end

    assign o_data_r1 = r_data_r1;
    assign o_data_r2 = r_data_r2;
    assign o_r_valid = r_r_valid;
    assign o_busy    = w_busy;

endmodule
